// File: rtl/byte_pack_converter.sv
// byte_pack_converter: drops invalid input bytes and repacks the rest into OUT_BYTES words.
// Define BYTE_PACK_STATS_EN to add the stat_in_bytes / stat_out_words counters.
module byte_pack_converter #(
  parameter int         IN_BYTES  = 2,
  parameter int         OUT_BYTES = 3,
  parameter logic [7:0] PAD_BYTE  = 8'h00
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic [8*IN_BYTES-1:0]            in_data,
  input  logic [IN_BYTES-1:0]              in_byte_valid,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             flush_in,
  output logic [8*OUT_BYTES-1:0]           out_data,
  output logic                             out_valid,
  output logic                             out_last,
  output logic [$clog2(OUT_BYTES+1)-1:0]   out_byte_cnt,
  input  logic                             out_ready
`ifdef BYTE_PACK_STATS_EN
  ,
  output logic [31:0]                      stat_in_bytes,
  output logic [31:0]                      stat_out_words
`endif
);

  localparam int BUF_BYTES = IN_BYTES + OUT_BYTES;
  localparam int CW        = $clog2(BUF_BYTES + 1);
  localparam int OCW       = $clog2(OUT_BYTES + 1);

  logic [7:0]    mem_q [BUF_BYTES];
  logic [7:0]    mem_d [BUF_BYTES];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          flush_pend_q;
  logic          flush_pend_d;
  logic          accept;
  logic          pop;
  int            cnt;
  int            pop_n;
  int            pos;
  int            nv;

  assign cnt = int'(count_q);

  always_comb begin : status
    in_ready  = ~flush_pend_q & (cnt <= OUT_BYTES);
    out_valid = (cnt >= OUT_BYTES)
              | (flush_pend_q & (cnt > 0));
    out_last  = flush_pend_q & out_valid
              & (cnt <= OUT_BYTES);
    accept    = in_valid & in_ready;
    pop       = out_valid & out_ready;
    pop_n     = 0;
    if (pop)
      pop_n = (cnt < OUT_BYTES) ? cnt : OUT_BYTES;
  end

  // Head of the buffer is the MSB byte; short words are padded.
  always_comb begin : out_fields
    out_data     = '0;
    out_byte_cnt = '0;
    if (out_valid) begin
      for (int j = 0; j < OUT_BYTES; j++)
        out_data[8*(OUT_BYTES-1-j) +: 8] =
          (j < cnt) ? mem_q[j] : PAD_BYTE;
      out_byte_cnt = (cnt < OUT_BYTES)
                   ? OCW'(cnt)
                   : OCW'(OUT_BYTES);
    end
  end

  always_comb begin : next_state
    for (int k = 0; k < BUF_BYTES; k++) begin
      mem_d[k] = 8'h00;
      for (int p = 0; p <= OUT_BYTES; p++)
        if (pop_n == p && k + p < BUF_BYTES)
          mem_d[k] = mem_q[(k + p) % BUF_BYTES];
    end
    // Compact valid bytes, highest index first, behind the survivors.
    pos = cnt - pop_n;
    nv  = 0;
    if (accept) begin
      for (int i = IN_BYTES - 1; i >= 0; i--) begin
        if (in_byte_valid[i]) begin
          for (int k = 0; k < BUF_BYTES; k++)
            if (k == pos)
              mem_d[k] = in_data[8*i +: 8];
          pos = pos + 1;
          nv  = nv + 1;
        end
      end
    end
    count_d      = CW'(cnt - pop_n + nv);
    flush_pend_d = flush_pend_q;
    unique case (1'b1)
      flush_pend_q & ((pop & out_last) | (cnt == 0)):
        flush_pend_d = 1'b0;
      ~flush_pend_q & flush_in:
        flush_pend_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      count_q      <= '0;
      flush_pend_q <= 1'b0;
      for (int k = 0; k < BUF_BYTES; k++)
        mem_q[k] <= 8'h00;
    end else begin
      count_q      <= count_d;
      flush_pend_q <= flush_pend_d;
      for (int k = 0; k < BUF_BYTES; k++)
        mem_q[k] <= mem_d[k];
    end
  end

`ifdef BYTE_PACK_STATS_EN
  // Counters restart at each frame boundary.
  always_ff @(posedge clock) begin
    if (rst || (pop && out_last)) begin
      stat_in_bytes  <= '0;
      stat_out_words <= '0;
    end else begin
      stat_in_bytes <= stat_in_bytes + 32'(nv);
      if (pop)
        stat_out_words <= stat_out_words + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_byte_pack_converter.sv
// tb_byte_pack_converter: directed and random checks of byte_pack_converter
// against a byte-queue reference model, for 2->3 and 4->3 configurations.
module tb_byte_pack_converter;

  localparam int OB = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst;
  logic [31:0] drv_data;
  logic [3:0]  drv_mask;
  logic        drv_valid;
  logic        drv_flush;
  logic        drv_ready;
  logic        sel;

  logic [15:0] a_in_data;
  logic [1:0]  a_mask;
  logic        a_in_valid, a_flush, a_in_ready;
  logic [23:0] a_out_data;
  logic        a_out_valid, a_out_last;
  logic [1:0]  a_out_cnt;

  logic        b_in_valid, b_flush, b_in_ready;
  logic [23:0] b_out_data;
  logic        b_out_valid, b_out_last;
  logic [1:0]  b_out_cnt;

  logic [23:0] obs_data;
  logic        obs_valid, obs_last, obs_ready;
  logic [1:0]  obs_cnt;

  assign a_in_data  = drv_data[15:0];
  assign a_mask     = drv_mask[1:0];
  assign a_in_valid = drv_valid & ~sel;
  assign a_flush    = drv_flush & ~sel;
  assign b_in_valid = drv_valid & sel;
  assign b_flush    = drv_flush & sel;

  assign obs_data  = sel ? b_out_data  : a_out_data;
  assign obs_valid = sel ? b_out_valid : a_out_valid;
  assign obs_last  = sel ? b_out_last  : a_out_last;
  assign obs_cnt   = sel ? b_out_cnt   : a_out_cnt;
  assign obs_ready = sel ? b_in_ready  : a_in_ready;

  byte_pack_converter #(
    .IN_BYTES(2), .OUT_BYTES(3), .PAD_BYTE(8'h00)
  ) dut_a (
    .clock(clock), .rst(rst),
    .in_data(a_in_data), .in_byte_valid(a_mask),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .flush_in(a_flush),
    .out_data(a_out_data), .out_valid(a_out_valid),
    .out_last(a_out_last), .out_byte_cnt(a_out_cnt),
    .out_ready(drv_ready)
  );

  byte_pack_converter #(
    .IN_BYTES(4), .OUT_BYTES(3), .PAD_BYTE(8'hFF)
  ) dut_b (
    .clock(clock), .rst(rst),
    .in_data(drv_data), .in_byte_valid(drv_mask),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .flush_in(b_flush),
    .out_data(b_out_data), .out_valid(b_out_valid),
    .out_last(b_out_last), .out_byte_cnt(b_out_cnt),
    .out_ready(drv_ready)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  mq[$];
  bit          mfp;
  logic [31:0] wlog[$];

  function automatic int ib();
    return sel ? 4 : 2;
  endfunction

  function automatic logic [7:0] pad();
    return sel ? 8'hFF : 8'h00;
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // One clock: check outputs against the queue model, then apply handshakes.
  task automatic cycle(output bit acc);
    int          sz;
    int          n;
    logic [31:0] ed;
    bit          ev, er, el, pop, nfp;
    @(negedge clock);
    sz = mq.size();
    ev = (sz >= OB) || (mfp && sz > 0);
    er = !mfp && (sz <= OB);
    chk("out_valid", 32'(obs_valid), 32'(ev));
    chk("in_ready", 32'(obs_ready), 32'(er));
    el = 1'b0;
    n  = 0;
    if (ev) begin
      n  = (sz < OB) ? sz : OB;
      ed = '0;
      for (int j = 0; j < OB; j++)
        ed[8*(OB-1-j) +: 8] = (j < n) ? mq[j] : pad();
      el = mfp && (sz <= OB);
      chk("out_data", 32'(obs_data), ed);
      chk("out_byte_cnt", 32'(obs_cnt), 32'(n));
      chk("out_last", 32'(obs_last), 32'(el));
    end
    pop = ev && drv_ready;
    acc = drv_valid && er;
    nfp = mfp;
    if (mfp && ((pop && el) || sz == 0))
      nfp = 1'b0;
    else if (!mfp && drv_flush)
      nfp = 1'b1;
    if (pop) begin
      wlog.push_back({5'd0, obs_last, obs_cnt, obs_data});
      repeat (n) void'(mq.pop_front());
    end
    if (acc)
      for (int i = ib() - 1; i >= 0; i--)
        if (drv_mask[i])
          mq.push_back(drv_data[8*i +: 8]);
    mfp = nfp;
    @(posedge clock);
    #1;
  endtask

  task automatic send(logic [31:0] d, logic [3:0] m);
    bit acc = 1'b0;
    drv_data  = d;
    drv_mask  = m;
    drv_valid = 1'b1;
    for (int t = 0; t < 20 && !acc; t++)
      cycle(acc);
    if (!acc)
      chk("send_timeout", 32'(acc), 32'd1);
    drv_valid = 1'b0;
  endtask

  task automatic idle(int n);
    bit a;
    drv_valid = 1'b0;
    repeat (n) cycle(a);
  endtask

  task automatic flush_pulse();
    bit a;
    drv_valid = 1'b0;
    drv_flush = 1'b1;
    cycle(a);
    drv_flush = 1'b0;
  endtask

  task automatic drain();
    bit a;
    int t = 0;
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    while ((mq.size() > 0 || mfp) && t < 40) begin
      cycle(a);
      t++;
    end
  endtask

  task automatic do_reset();
    drv_valid = 1'b0;
    drv_flush = 1'b0;
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    mq.delete();
    mfp = 1'b0;
  endtask

  task automatic rand_run(int n);
    bit a;
    for (int c = 0; c < n; c++) begin
      drv_data  = $urandom;
      drv_mask  = 4'($urandom);
      drv_valid = ($urandom_range(3) != 0);
      drv_ready = ($urandom_range(3) != 0);
      drv_flush = ($urandom_range(15) == 0);
      cycle(a);
    end
    drv_flush = 1'b0;
    flush_pulse();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          acc;
    logic [7:0]  r;
    int          s;
    rst = 1'b1;
    drv_data = '0;
    drv_mask = '0;
    drv_valid = 1'b0;
    drv_flush = 1'b0;
    drv_ready = 1'b1;
    sel = 1'b0;
    mfp = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_last", 32'(a_out_last), 32'd0);
    chk("rst_out_cnt", 32'(a_out_cnt), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    @(posedge clock);
    #1;

    wlog.delete();
    send(32'hAABB, 4'b0011);
    send(32'hCCDD, 4'b0011);
    send(32'hEEFF, 4'b0011);
    idle(2);
    chk("t1_words", 32'(wlog.size()), 32'd2);
    chk("t1_w0", wlog[0], 32'h03AABBCC);
    chk("t1_w1", wlog[1], 32'h03DDEEFF);

    wlog.delete();
    send(32'hAABB, 4'b0011);
    send(32'h55DD, 4'b0001);
    send(32'hEE66, 4'b0010);
    send(32'h1122, 4'b0011);
    idle(2);
    chk("t2_w0", wlog[0], 32'h03AABBDD);
    chk("t2_w1", wlog[1], 32'h03EE1122);
    chk("t2_empty", 32'(a_out_valid), 32'd0);

    wlog.delete();
    send(32'h1234, 4'b0011);
    flush_pulse();
    idle(2);
    chk("t3_words", 32'(wlog.size()), 32'd1);
    chk("t3_last_word", wlog[0], 32'h06123400);
    chk("t3_in_ready", 32'(a_in_ready), 32'd1);

    wlog.delete();
    drv_ready = 1'b0;
    send(32'h1122, 4'b0011);
    send(32'h9933, 4'b0001);
    flush_pulse();
    drv_ready = 1'b1;
    idle(2);
    chk("t4_full_last", wlog[0], 32'h07112233);

    wlog.delete();
    r = 8'h00;
    drv_ready = 1'b0;
    drv_valid = 1'b1;
    drv_mask  = 4'b0011;
    for (int c = 0; c < 16; c++) begin
      if (c == 10)
        drv_ready = 1'b1;
      drv_data = {16'h0, r, r + 8'd1};
      drv_valid = 1'b1;
      cycle(acc);
      if (acc)
        r = r + 8'd2;
    end
    drv_valid = 1'b0;
    flush_pulse();
    drain();
    s = 0;
    foreach (wlog[i])
      s += int'(wlog[i][25:24]);
    chk("t5_byte_total", 32'(s), 32'(r));

    send(32'hAABB, 4'b0011);
    do_reset();
    idle(1);
    wlog.delete();
    send(32'hC0C1, 4'b0011);
    send(32'hC2C3, 4'b0011);
    idle(2);
    chk("t6_after_rst", wlog[0], 32'h03C0C1C2);

    rand_run(300);

    do_reset();
    sel = 1'b1;
    wlog.delete();
    for (int w = 0; w < 5; w++)
      send({8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)},
           4'hF);
    flush_pulse();
    drain();
    chk("b_words", 32'(wlog.size()), 32'd7);
    chk("b_first", wlog[0], 32'h03000102);
    chk("b_last", wlog[6], 32'h061213FF);

    rand_run(300);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
